// File: rtl/cpu_ctrl_mem.sv
// Control FSM for the simple RISC datapath: fetch, PC update, ALU ops, LDR/STR
// with a memory ready handshake, HALT, illegal-opcode and memory-timeout traps.
module cpu_ctrl_mem #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       mem_ready,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] nsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       err
);

  localparam logic [4:0] S_RST   = 5'd0;
  localparam logic [4:0] S_IF    = 5'd1;
  localparam logic [4:0] S_UPC   = 5'd2;
  localparam logic [4:0] S_DEC   = 5'd3;
  localparam logic [4:0] S_MOVI  = 5'd4;
  localparam logic [4:0] S_GETA  = 5'd5;
  localparam logic [4:0] S_GETB  = 5'd6;
  localparam logic [4:0] S_ALU   = 5'd7;
  localparam logic [4:0] S_CMP   = 5'd8;
  localparam logic [4:0] S_WB    = 5'd9;
  localparam logic [4:0] S_ADR   = 5'd10;
  localparam logic [4:0] S_LADDR = 5'd11;
  localparam logic [4:0] S_MEMRD = 5'd12;
  localparam logic [4:0] S_STRB  = 5'd13;
  localparam logic [4:0] S_STRC  = 5'd14;
  localparam logic [4:0] S_MEMWR = 5'd15;
  localparam logic [4:0] S_HALT  = 5'd16;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};
  localparam logic            TO_EN    = (MEM_TIMEOUT != 0);

  logic [4:0]      state_r;
  logic [4:0]      next_s;
  logic [TO_W-1:0] to_cnt_r;
  logic            err_r;
  logic            set_err_s;
  logic            wait_s;
  logic            timeout_s;
  logic [4:0]      ir_op_s;
  logic            asel_reg_mov_s;

  assign ir_op_s        = {opcode, op};
  assign asel_reg_mov_s = (ir_op_s == 5'b11000) || (ir_op_s == 5'b10111);
  assign wait_s         = (state_r == S_IF) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  // A ready on the limit cycle wins, so the trap also requires mem_ready low.
  assign timeout_s      = TO_EN && (to_cnt_r == TO_LIMIT) && !mem_ready;

  // Next-state and trap decision.
  always_comb begin
    next_s    = state_r;
    set_err_s = 1'b0;
    case (state_r)
      S_RST:   next_s = S_IF;
      S_IF, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          next_s = (state_r == S_IF) ? S_UPC : S_IF;
        end else if (timeout_s) begin
          next_s    = S_HALT;
          set_err_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      S_UPC:   next_s = S_DEC;
      S_DEC: begin
        case (ir_op_s)
          5'b11010:                     next_s = S_MOVI;
          5'b11000, 5'b10111:           next_s = S_GETB;
          5'b10100, 5'b10101, 5'b10110,
          5'b01100, 5'b10000:           next_s = S_GETA;
          5'b11100:                     next_s = S_HALT;
          default: begin
            next_s    = S_HALT;
            set_err_s = 1'b1;
          end
        endcase
      end
      S_GETA:  next_s = (opcode == 3'b101) ? S_GETB : S_ADR;
      S_GETB:  next_s = (ir_op_s == 5'b10101) ? S_CMP : S_ALU;
      S_ALU:   next_s = S_WB;
      S_CMP:   next_s = S_IF;
      S_WB:    next_s = S_IF;
      S_MOVI:  next_s = S_IF;
      S_ADR:   next_s = S_LADDR;
      S_LADDR: next_s = (opcode == 3'b011) ? S_MEMRD : S_STRB;
      S_STRB:  next_s = S_STRC;
      S_STRC:  next_s = S_MEMWR;
      S_HALT:  next_s = S_HALT;
      default: begin
        next_s    = S_HALT;
        set_err_s = 1'b1;
      end
    endcase
  end

  // State register and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_RST;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      err_r   <= err_r | set_err_s;
    end
  end

  // Memory-wait counter: restarts on every state change, saturates while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (next_s != state_r) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (wait_s && !mem_ready && (to_cnt_r != TO_MAX)) begin
      to_cnt_r <= to_cnt_r + TO_W'(1'b1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Moore output decode; load_ir and write additionally gated by mem_ready.
  always_comb begin
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    nsel      = 3'b000;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = 2'b00;
    halted    = 1'b0;
    case (state_r)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        load_ir  = mem_ready;
      end
      S_UPC:   load_pc = 1'b1;
      S_DEC:   vsel    = 2'b00;
      S_MOVI: begin
        vsel  = 2'b10;
        write = 1'b1;
        nsel  = 3'b100;
      end
      S_GETA: begin
        loada = 1'b1;
        nsel  = 3'b100;
      end
      S_GETB: begin
        loadb = 1'b1;
        nsel  = 3'b001;
      end
      S_ALU: begin
        loadc = 1'b1;
        asel  = asel_reg_mov_s;
      end
      S_CMP:   loads = 1'b1;
      S_WB: begin
        write = 1'b1;
        nsel  = 3'b010;
      end
      S_ADR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LADDR: load_addr = 1'b1;
      S_MEMRD: begin
        mem_cmd = 2'b01;
        vsel    = 2'b11;
        nsel    = 3'b010;
        write   = mem_ready;
      end
      S_STRB: begin
        loadb = 1'b1;
        nsel  = 3'b010;
      end
      S_STRC: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEMWR: mem_cmd = 2'b10;
      S_HALT:  halted  = 1'b1;
      default: halted  = 1'b1;
    endcase
  end

  assign err = err_r;

endmodule

// File: tb/tb_cpu_ctrl_mem.sv
// Scoreboard bench for cpu_ctrl_mem: each cycle's expected output vector is
// queued by the stimulus and compared by an independent monitor on negedge.
module tb_cpu_ctrl_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;
  logic [1:0] vsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0] nsel;
  logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
  logic [1:0] mem_cmd;
  logic       halted, err;

  cpu_ctrl_mem #(.MEM_TIMEOUT(3), .TO_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .mem_ready(mem_ready),
    .vsel(vsel), .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .nsel(nsel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_addr(load_addr),
    .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // Output vector bit fields.
  localparam logic [20:0] VS_IMM    = 21'd2 << 19;
  localparam logic [20:0] VS_MD     = 21'd3 << 19;
  localparam logic [20:0] B_WRITE   = 21'd1 << 18;
  localparam logic [20:0] B_LOADA   = 21'd1 << 17;
  localparam logic [20:0] B_LOADB   = 21'd1 << 16;
  localparam logic [20:0] B_LOADC   = 21'd1 << 15;
  localparam logic [20:0] B_LOADS   = 21'd1 << 14;
  localparam logic [20:0] B_ASEL    = 21'd1 << 13;
  localparam logic [20:0] B_BSEL    = 21'd1 << 12;
  localparam logic [20:0] NS_RN     = 21'd4 << 9;
  localparam logic [20:0] NS_RD     = 21'd2 << 9;
  localparam logic [20:0] NS_RM     = 21'd1 << 9;
  localparam logic [20:0] B_LOAD_IR = 21'd1 << 8;
  localparam logic [20:0] B_LOAD_PC = 21'd1 << 7;
  localparam logic [20:0] B_RST_PC  = 21'd1 << 6;
  localparam logic [20:0] B_LADDR   = 21'd1 << 5;
  localparam logic [20:0] B_ASELPC  = 21'd1 << 4;
  localparam logic [20:0] CMD_RD    = 21'd1 << 2;
  localparam logic [20:0] CMD_WR    = 21'd2 << 2;
  localparam logic [20:0] B_HALTED  = 21'd1 << 1;
  localparam logic [20:0] B_ERR     = 21'd1;

  localparam logic [20:0] E_RST   = B_LOAD_PC | B_RST_PC;
  localparam logic [20:0] E_UPC   = B_LOAD_PC;
  localparam logic [20:0] E_DEC   = 21'd0;
  localparam logic [20:0] E_MOVI  = VS_IMM | B_WRITE | NS_RN;
  localparam logic [20:0] E_GETA  = B_LOADA | NS_RN;
  localparam logic [20:0] E_GETB  = B_LOADB | NS_RM;
  localparam logic [20:0] E_CMP   = B_LOADS;
  localparam logic [20:0] E_WB    = B_WRITE | NS_RD;
  localparam logic [20:0] E_ADR   = B_BSEL | B_LOADC;
  localparam logic [20:0] E_LADDR = B_LADDR;
  localparam logic [20:0] E_STRB  = B_LOADB | NS_RD;
  localparam logic [20:0] E_STRC  = B_ASEL | B_LOADC;
  localparam logic [20:0] E_MEMWR = CMD_WR;
  localparam logic [20:0] E_HALT  = B_HALTED;
  localparam logic [20:0] E_HERR  = B_HALTED | B_ERR;
  localparam logic [20:0] E_IF0   = B_ASELPC | CMD_RD;
  localparam logic [20:0] E_IF1   = B_ASELPC | CMD_RD | B_LOAD_IR;
  localparam logic [20:0] E_ALU0  = B_LOADC;
  localparam logic [20:0] E_ALU1  = B_LOADC | B_ASEL;
  localparam logic [20:0] E_RD0   = CMD_RD | VS_MD | NS_RD;
  localparam logic [20:0] E_RD1   = CMD_RD | VS_MD | NS_RD | B_WRITE;

  logic [20:0] act;
  assign act = {vsel, write, loada, loadb, loadc, loads, asel, bsel, nsel,
                load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted, err};

  string       nm_q[$];
  logic [20:0] v_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Monitor: pop and compare one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (v_q.size() > 0) begin
      string       nm;
      logic [20:0] e;
      nm = nm_q.pop_front();
      e  = v_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %06h expected %06h", nm, act, e);
    end
  end

  task automatic step(input string nm, input logic rdy, input logic rst,
                      input logic chk, input logic [20:0] e);
    mem_ready = rdy;
    reset     = rst;
    if (chk) begin
      nm_q.push_back(nm);
      v_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op     = o;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opcode = 3'b110; op = 2'b10;
    @(posedge clk); #1;
    step("pre", 1'b1, 1'b1, 1'b0, 21'd0);
    reset = 1'b0;

    // MOV R0,#5
    set_ir(3'b110, 2'b10);
    step("mov.rst",  1'b1, 1'b0, 1'b1, E_RST);
    step("mov.if",   1'b1, 1'b0, 1'b1, E_IF1);
    step("mov.upc",  1'b1, 1'b0, 1'b1, E_UPC);
    step("mov.dec",  1'b1, 1'b0, 1'b1, E_DEC);
    step("mov.movi", 1'b1, 1'b0, 1'b1, E_MOVI);
    // ADD
    set_ir(3'b101, 2'b00);
    step("add.if",   1'b1, 1'b0, 1'b1, E_IF1);
    step("add.upc",  1'b1, 1'b0, 1'b1, E_UPC);
    step("add.dec",  1'b1, 1'b0, 1'b1, E_DEC);
    step("add.geta", 1'b1, 1'b0, 1'b1, E_GETA);
    step("add.getb", 1'b1, 1'b0, 1'b1, E_GETB);
    step("add.alu",  1'b1, 1'b0, 1'b1, E_ALU0);
    step("add.wb",   1'b1, 1'b0, 1'b1, E_WB);
    // CMP
    set_ir(3'b101, 2'b01);
    step("cmp.if",   1'b1, 1'b0, 1'b1, E_IF1);
    step("cmp.upc",  1'b1, 1'b0, 1'b1, E_UPC);
    step("cmp.dec",  1'b1, 1'b0, 1'b1, E_DEC);
    step("cmp.geta", 1'b1, 1'b0, 1'b1, E_GETA);
    step("cmp.getb", 1'b1, 1'b0, 1'b1, E_GETB);
    step("cmp.cmp",  1'b1, 1'b0, 1'b1, E_CMP);
    // MVN: skips GETA, asel=1 in ALU
    set_ir(3'b101, 2'b11);
    step("mvn.if",   1'b1, 1'b0, 1'b1, E_IF1);
    step("mvn.upc",  1'b1, 1'b0, 1'b1, E_UPC);
    step("mvn.dec",  1'b1, 1'b0, 1'b1, E_DEC);
    step("mvn.getb", 1'b1, 1'b0, 1'b1, E_GETB);
    step("mvn.alu",  1'b1, 1'b0, 1'b1, E_ALU1);
    step("mvn.wb",   1'b1, 1'b0, 1'b1, E_WB);
    // LDR with 3 wait cycles; ready arrives exactly at the timeout limit
    set_ir(3'b011, 2'b00);
    step("ldr.if",    1'b1, 1'b0, 1'b1, E_IF1);
    step("ldr.upc",   1'b1, 1'b0, 1'b1, E_UPC);
    step("ldr.dec",   1'b1, 1'b0, 1'b1, E_DEC);
    step("ldr.geta",  1'b1, 1'b0, 1'b1, E_GETA);
    step("ldr.adr",   1'b1, 1'b0, 1'b1, E_ADR);
    step("ldr.laddr", 1'b1, 1'b0, 1'b1, E_LADDR);
    for (int i = 0; i < 3; i++) step("ldr.memrd_wait", 1'b0, 1'b0, 1'b1, E_RD0);
    step("ldr.memrd_rdy", 1'b1, 1'b0, 1'b1, E_RD1);
    // STR
    set_ir(3'b100, 2'b00);
    step("str.if",    1'b1, 1'b0, 1'b1, E_IF1);
    step("str.upc",   1'b1, 1'b0, 1'b1, E_UPC);
    step("str.dec",   1'b1, 1'b0, 1'b1, E_DEC);
    step("str.geta",  1'b1, 1'b0, 1'b1, E_GETA);
    step("str.adr",   1'b1, 1'b0, 1'b1, E_ADR);
    step("str.laddr", 1'b1, 1'b0, 1'b1, E_LADDR);
    step("str.strb",  1'b1, 1'b0, 1'b1, E_STRB);
    step("str.strc",  1'b1, 1'b0, 1'b1, E_STRC);
    step("str.memwr", 1'b1, 1'b0, 1'b1, E_MEMWR);
    // Fetch stalled for 2 cycles then ready
    set_ir(3'b110, 2'b10);
    step("ifw.wait0", 1'b0, 1'b0, 1'b1, E_IF0);
    step("ifw.wait1", 1'b0, 1'b0, 1'b1, E_IF0);
    step("ifw.rdy",   1'b1, 1'b0, 1'b1, E_IF1);
    step("ifw.upc",   1'b1, 1'b0, 1'b1, E_UPC);
    step("ifw.dec",   1'b1, 1'b0, 1'b1, E_DEC);
    step("ifw.movi",  1'b1, 1'b0, 1'b1, E_MOVI);
    // Fetch timeout: 4 IF cycles then HALT with err
    for (int i = 0; i < 4; i++) step("to.if", 1'b0, 1'b0, 1'b1, E_IF0);
    step("to.halt0", 1'b0, 1'b0, 1'b1, E_HERR);
    step("to.halt1", 1'b1, 1'b0, 1'b1, E_HERR);
    step("to.halt_rst", 1'b1, 1'b1, 1'b1, E_HERR);
    // Illegal opcode
    set_ir(3'b000, 2'b00);
    step("ill.rst",  1'b1, 1'b0, 1'b1, E_RST);
    step("ill.if",   1'b1, 1'b0, 1'b1, E_IF1);
    step("ill.upc",  1'b1, 1'b0, 1'b1, E_UPC);
    step("ill.dec",  1'b1, 1'b0, 1'b1, E_DEC);
    step("ill.halt", 1'b1, 1'b1, 1'b1, E_HERR);
    // HALT instruction
    set_ir(3'b111, 2'b00);
    step("hlt.rst",   1'b1, 1'b0, 1'b1, E_RST);
    step("hlt.if",    1'b1, 1'b0, 1'b1, E_IF1);
    step("hlt.upc",   1'b1, 1'b0, 1'b1, E_UPC);
    step("hlt.dec",   1'b1, 1'b0, 1'b1, E_DEC);
    step("hlt.halt0", 1'b1, 1'b0, 1'b1, E_HALT);
    step("hlt.halt1", 1'b0, 1'b1, 1'b1, E_HALT);
    // STR with reset during the MEMWR wait
    set_ir(3'b100, 2'b00);
    step("rsw.rst",   1'b1, 1'b0, 1'b1, E_RST);
    step("rsw.if",    1'b1, 1'b0, 1'b1, E_IF1);
    step("rsw.upc",   1'b1, 1'b0, 1'b1, E_UPC);
    step("rsw.dec",   1'b1, 1'b0, 1'b1, E_DEC);
    step("rsw.geta",  1'b1, 1'b0, 1'b1, E_GETA);
    step("rsw.adr",   1'b1, 1'b0, 1'b1, E_ADR);
    step("rsw.laddr", 1'b1, 1'b0, 1'b1, E_LADDR);
    step("rsw.strb",  1'b1, 1'b0, 1'b1, E_STRB);
    step("rsw.strc",  1'b1, 1'b0, 1'b1, E_STRC);
    step("rsw.memwr", 1'b0, 1'b0, 1'b1, E_MEMWR);
    step("rsw.memwr_rst", 1'b0, 1'b1, 1'b1, E_MEMWR);
    step("rsw.after", 1'b0, 1'b0, 1'b1, E_RST);

    for (int i = 0; i < 10 && v_q.size() > 0; i++) @(negedge clk);
    if (v_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", v_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_mem.md
Name: cpu_ctrl_mem

Overview:
Second-generation control FSM for the simple RISC datapath. It adds autonomous instruction fetch, PC update, LDR/STR with a ready handshake to memory, HALT, illegal-opcode trapping, and a parametrised memory-wait timeout. It replaces the start/wait (s/w) handshake. It drives the existing datapath strobes plus the new PC, IR, address and memory strobes. It sits between the instruction decoder and the datapath/memory interface.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive mem_ready=0 cycles in a memory-wait state before trapping; 0 disables the timeout.
TO_W, 4, timeout counter width; MEM_TIMEOUT must be < 2^TO_W.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
opcode  in  3  IR[15:13]
op  in  2  IR[12:11]
mem_ready  in  1  memory has completed the current command
vsel  out  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata
write  out  1  register-file write enable
loada, loadb, loadc, loads  out  1 each  pipeline and status register loads
asel, bsel  out  1 each  ALU source selects (asel=1 gives 0 on A; bsel=1 gives sximm5 on B)
nsel  out  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm, 000 none
load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1 each  addr_sel=1 selects PC, 0 selects the data-address register
mem_cmd  out  2  00 none, 01 read, 10 write
halted  out  1  FSM is in HALT
err  out  1  sticky trap flag (illegal opcode or timeout)

Behaviour:
- State register updates on the rising clk edge. If reset=1 at an edge: state becomes RST, the timeout counter becomes 0, err becomes 0.
- Outputs are Moore, except two terms qualified by mem_ready: load_ir in IF and write in MEMRD.
- Every output not listed for a state is 0. RST outputs: reset_pc=1, load_pc=1, all else 0.
- States, listed as outputs followed by the next state:
  - RST: -> IF.
  - IF: addr_sel=1, mem_cmd=01, load_ir=mem_ready; -> UPC when mem_ready=1, else stay.
  - UPC: load_pc=1; -> DEC.
  - DEC: no outputs. Dispatch on {opcode,op}:
    - 11010 -> MOVI
    - 11000 or 10111 -> GETB
    - 10100, 10101 or 10110 -> GETA
    - 01100 or 10000 -> GETA
    - 11100 -> HALT
    - anything else -> HALT with err set.
  - MOVI: vsel=10, write=1, nsel=100; -> IF.
  - GETA: loada=1, nsel=100; -> GETB for ALU ops, ADR for LDR/STR.
  - GETB: loadb=1, nsel=001; -> CMP for 10101, else ALU.
  - ALU: loadc=1; asel=1 for MOV-reg/MVN, else 0; -> WB.
  - CMP: loads=1; -> IF.
  - WB: vsel=00, write=1, nsel=010; -> IF.
  - ADR: bsel=1, loadc=1; -> LADDR.
  - LADDR: load_addr=1; -> MEMRD for LDR, STRB for STR.
  - MEMRD: addr_sel=0, mem_cmd=01, vsel=11, nsel=010, write=mem_ready; -> IF on mem_ready.
  - STRB: loadb=1, nsel=010; -> STRC.
  - STRC: asel=1, loadc=1; -> MEMWR.
  - MEMWR: addr_sel=0, mem_cmd=10; -> IF on mem_ready.
  - HALT: halted=1; stays in HALT until reset.
- Latency from IF entry with zero memory wait:
  - MOV imm: 4 cycles
  - CMP, MOV reg, MVN: 6 cycles
  - ADD, AND: 7 cycles
  - LDR: 7 cycles
  - STR: 9 cycles
- Each cycle with mem_ready=0 in IF, MEMRD or MEMWR adds one cycle.
- Timeout counter (TO_W bits):
  - Cleared on entry to IF, MEMRD or MEMWR.
  - Increments each cycle spent in a wait state with mem_ready=0.
  - If the counter equals MEM_TIMEOUT (nonzero) while mem_ready=0: next state is HALT, err is set. mem_cmd deasserts the next cycle.
  - mem_ready=1 on the same cycle the limit is reached wins: no trap.
  - The counter saturates and never wraps.
- Reset mid-operation, including during a memory wait: the transaction is abandoned. The next cycle is RST with mem_cmd=00 and no write.
- mem_ready is ignored in every state except IF, MEMRD and MEMWR.
- err stays 1 until reset.

Test Plan:
- Reset pulse, then mem_ready=1 constantly, IR=MOV R0,#5 (11010): cycle trace RST, IF(load_ir=1), UPC(load_pc=1), DEC, MOVI(vsel=10, write=1, nsel=100), IF. halted=0, err=0.
- ADD R2,R1,R0 with mem_ready=1: exactly 7 cycles IF..WB. WB has write=1, nsel=010, vsel=00. loads=0 throughout. Then CMP: loads=1 only in the CMP state, write never 1.
- LDR with mem_ready held 0 for 3 cycles in MEMRD: mem_cmd=01 for 4 cycles, write=1 only on the mem_ready cycle, then IF.
- STR: STRB nsel=010 loadb=1, STRC asel=1 loadc=1, MEMWR mem_cmd=10 addr_sel=0. Completes on mem_ready; 9 cycles total.
- MEM_TIMEOUT=3, mem_ready stuck 0 in IF: HALT entered after exactly 4 IF cycles, err=1, halted=1, mem_cmd=00. Remains halted; the next reset clears err and returns to RST.
- Illegal {opcode,op}=00000 -> HALT with err=1. HALT instruction 11100 -> halted=1, err=0. Reset asserted mid-MEMWR -> next cycle RST, mem_cmd=00.
